// File: rtl/chip_test_sequencer.sv
// Chip test sequencer: launches a checker run on a Start edge, waits for its
// result with a timeout, shows the outcome on LEDs, then acknowledges it.
module chip_test_sequencer #(
  parameter logic [15:0] HOLD_CYCLES    = 16'd50000,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Start,
  output logic       Run,
  input  logic       Done,
  input  logic       RSLT,
  output logic       DISP_RSLT,
  output logic       Busy,
  output logic       Pass_LED,
  output logic       Fail_LED,
  output logic       Timeout_LED,
  output logic [7:0] Pass_Count,
  output logic [7:0] Fail_Count
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TALLY_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_WAIT   = 3'd2,
    S_SETTLE = 3'd3,
    S_SHOW   = 3'd4,
    S_ACK    = 3'd5,
    S_DRAIN  = 3'd6
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic               start_q;
  logic               start_armed;
  logic               start_edge_c;
  logic               hold_done_c;
  logic               timeout_c;

  logic [CNT_W-1:0]   cnt_d;
  logic               run_d;
  logic               disp_d;
  logic               busy_d;
  logic               pass_led_d;
  logic               fail_led_d;
  logic               timeout_led_d;
  logic [TALLY_W-1:0] pass_cnt_d;
  logic [TALLY_W-1:0] fail_cnt_d;

  // Edge only counts once Start has been seen low after reset, so a level held
  // through reset release is never mistaken for a new request.
  assign start_edge_c = Start & ~start_q & start_armed;
  assign hold_done_c  = (cnt == CNT_W'(HOLD_CYCLES - 16'd1));
  assign timeout_c    = (cnt == CNT_W'(TIMEOUT_CYCLES - 16'd1));

  // Start edge-detect history
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      start_q     <= 1'b0;
      start_armed <= 1'b0;
    end else begin
      start_q     <= Start;
      start_armed <= start_armed | ~Start;
    end
  end

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start_edge_c) next_state = S_RUN;
      S_RUN:    next_state = S_WAIT;
      S_WAIT: begin
        if (Done)           next_state = S_SETTLE;
        else if (timeout_c) next_state = S_IDLE;
      end
      S_SETTLE: next_state = Done ? S_SHOW : S_WAIT;
      S_SHOW:   if (hold_done_c) next_state = S_ACK;
      S_ACK: begin
        if (!Done)          next_state = S_DRAIN;
        else if (timeout_c) next_state = S_IDLE;
      end
      S_DRAIN:  next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Next values of counter, LEDs, tallies and the state-aligned strobes
  always_comb begin
    cnt_d         = cnt;
    pass_led_d    = Pass_LED;
    fail_led_d    = Fail_LED;
    timeout_led_d = Timeout_LED;
    pass_cnt_d    = Pass_Count;
    fail_cnt_d    = Fail_Count;
    run_d         = (next_state == S_RUN);
    disp_d        = (next_state == S_ACK);
    busy_d        = (next_state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start_edge_c) begin
          cnt_d         = '0;
          pass_led_d    = 1'b0;
          fail_led_d    = 1'b0;
          timeout_led_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (!Done) begin
          if (timeout_c) begin
            timeout_led_d = 1'b1;
            fail_led_d    = 1'b1;
            if (Fail_Count != 8'hFF) fail_cnt_d = Fail_Count + 8'd1;
          end else begin
            cnt_d = cnt + 16'd1;
          end
        end
      end
      S_SETTLE: begin
        if (Done) begin
          if (RSLT) begin
            pass_led_d = 1'b1;
            if (Pass_Count != 8'hFF) pass_cnt_d = Pass_Count + 8'd1;
          end else begin
            fail_led_d = 1'b1;
            if (Fail_Count != 8'hFF) fail_cnt_d = Fail_Count + 8'd1;
          end
          cnt_d = '0;
        end
      end
      S_SHOW:   cnt_d = hold_done_c ? '0 : cnt + 16'd1;
      S_ACK: begin
        if (Done) begin
          if (timeout_c) timeout_led_d = 1'b1;
          else           cnt_d = cnt + 16'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt         <= '0;
      Run         <= 1'b0;
      DISP_RSLT   <= 1'b0;
      Busy        <= 1'b0;
      Pass_LED    <= 1'b0;
      Fail_LED    <= 1'b0;
      Timeout_LED <= 1'b0;
      Pass_Count  <= '0;
      Fail_Count  <= '0;
    end else begin
      cnt         <= cnt_d;
      Run         <= run_d;
      DISP_RSLT   <= disp_d;
      Busy        <= busy_d;
      Pass_LED    <= pass_led_d;
      Fail_LED    <= fail_led_d;
      Timeout_LED <= timeout_led_d;
      Pass_Count  <= pass_cnt_d;
      Fail_Count  <= fail_cnt_d;
    end
  end

endmodule
